muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have one clock and one reset: the reset is asynchronous and active-low.
REQ-002 Parameter WIDTH, default 32, SHALL set the operand and result width in bits (legal values: WIDTH >= 4).
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port start, input, 1 bit: request to begin an operation; sampled only while ready=1.
REQ-006 Port funct3, input, 3 bits: operation select (RV32M Funct3 encoding); sampled with start.
REQ-007 Port op_a, input, WIDTH bits: multiplicand or dividend; sampled with start.
REQ-008 Port op_b, input, WIDTH bits: multiplier or divisor; sampled with start.
REQ-009 Port flush, input, 1 bit: synchronous abort of an in-flight operation.
REQ-010 Port ready, output, 1 bit: high exactly when the FSM is in IDLE.
REQ-011 Port busy, output, 1 bit: high in PREP, CALC and FIX.
REQ-012 Port done, output, 1 bit: one-cycle pulse marking that result is valid.
REQ-013 Port result, output, WIDTH bits: the operation result.

Function
REQ-014 funct3 encoding SHALL be: 000 MUL (low WIDTH bits), 001 MULH (signed x signed, high), 010 MULHSU (signed op_a x unsigned op_b, high), 011 MULHU (unsigned, high), 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-015 FSM states SHALL be IDLE, PREP, CALC, FIX and DONE, with these transitions:
- IDLE->PREP on start.
- PREP->CALC after 1 cycle.
- CALC->FIX after exactly WIDTH cycles (iteration counter 0..WIDTH-1).
- FIX->DONE after 1 cycle.
- DONE->IDLE after 1 cycle.
REQ-016 PREP SHALL register the operand magnitudes and the result-sign flags; CALC SHALL perform one shift-add (multiply) or one restoring subtract-shift (divide) step per cycle; FIX SHALL apply the sign correction and select the high/low half or the quotient/remainder.
REQ-017 Latency SHALL be fixed for every opcode and every operand value: done is high after the (WIDTH+3)th rising edge, counting the start-accepting edge as the 1st (35 edges for WIDTH=32).
REQ-018 done SHALL be high only in DONE, and result SHALL update on the edge that enters DONE.
REQ-019 result SHALL hold its value after DONE until the next entry into DONE.
REQ-020 start SHALL be ignored while ready=0; a start in the same cycle as DONE is ignored; back-to-back operations therefore require a start while in IDLE.
REQ-021 The multiplier SHALL use a 2*WIDTH-bit internal product; the divider SHALL use a WIDTH+1-bit partial remainder.
REQ-022 Divide by zero SHALL give a quotient of all ones (DIV and DIVU) and a remainder equal to op_a (REM and REMU), with normal latency.
REQ-023 Signed overflow (op_a = most-negative value, op_b = -1) SHALL give DIV = op_a and REM = 0.
REQ-024 Remainder sign SHALL follow the dividend, and the quotient SHALL truncate toward zero.
REQ-025 flush in PREP, CALC or FIX SHALL move the FSM to IDLE on the next edge: no done pulse, result unchanged.
REQ-026 flush in IDLE or DONE SHALL have no effect; flush and start high together in IDLE: start is ignored.
REQ-027 Operand inputs may change after the accepting edge without affecting the operation in flight.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, ready=1, busy=0, done=0, result=0, and clear the iteration counter and datapath registers, including in the middle of an operation.
REQ-029 The first start SHALL be accepted on the first rising edge with rst_n high.

Verification
REQ-030 WIDTH=32, MUL op_a=7, op_b=0xFFFFFFFD -> result 0xFFFFFFEB; done high after edge 35 for exactly 1 cycle; busy high for 32+2 cycles.
REQ-031 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
REQ-032 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 0x00000007; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-033 start re-asserted with new operands during CALC -> ignored; the original result is delivered at edge 35; the next start is accepted only after ready returns to 1.
REQ-034 flush at edge 10 of a DIVU -> ready=1 after edge 11; no done; result retains its prior value; a following MUL 3x4 -> 12.
REQ-035 rst_n pulsed low at edge 20 of a MULHU -> outputs immediately 0/ready=1; no done; the next operation completes correctly with full latency.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M-style multiply/divide unit with fixed WIDTH+3 cycle latency
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [2:0]         f_q;
  logic [WIDTH-1:0]   a_q, b_q, result_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH:0]     rem_q;
  logic               sa_q, sb_q, bz_q;
  logic               sa, sb;
  logic [WIDTH-1:0]   amag, bmag, qv, rv, res_d;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod_mul, pm;
  logic [WIDTH+1:0]   shifted, diff;
  assign sa       = (f_q == 3'b001 || f_q == 3'b010 || f_q == 3'b100 || f_q == 3'b110) && a_q[WIDTH-1];
  assign sb       = (f_q == 3'b001 || f_q == 3'b100 || f_q == 3'b110) && b_q[WIDTH-1];
  assign amag     = sa ? -a_q : a_q;
  assign bmag     = sb ? -b_q : b_q;
  assign sum      = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q & {WIDTH{prod_q[0]}}};
  assign prod_mul = {sum, prod_q[WIDTH-1:1]};
  assign shifted  = {rem_q, prod_q[WIDTH-1]};
  assign diff     = shifted - {2'b00, b_q};
  assign pm       = (sa_q ^ sb_q) ? -prod_q : prod_q;
  assign qv       = bz_q ? '1 : (sa_q ^ sb_q) ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
  assign rv       = sa_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
  assign res_d    = f_q[2] ? (f_q[1] ? rv : qv) : (f_q[1:0] == 2'b00 ? pm[WIDTH-1:0] : pm[2*WIDTH-1:WIDTH]);
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  // next-state logic; flush aborts any busy state, start is only honoured in IDLE without flush
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = (start && !flush) ? PREP : IDLE;
      PREP:    state_d = flush ? IDLE : CALC;
      CALC:    state_d = flush ? IDLE : (cnt_q == CW'(WIDTH-1)) ? FIX : CALC;
      FIX:     state_d = flush ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // status outputs decoded from the state
  always_comb begin
    ready = state_q == IDLE;
    busy  = state_q == PREP || state_q == CALC || state_q == FIX;
    done  = state_q == DONE;
  end
  // datapath: capture operands, load magnitudes, iterate, then sign-correct into result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      f_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      bz_q     <= 1'b0;
      result_q <= '0;
    end else begin
      if (state_q == IDLE && state_d == PREP) begin
        f_q <= funct3;
        a_q <= op_a;
        b_q <= op_b;
      end
      if (state_q == PREP) begin
        a_q    <= amag;
        b_q    <= bmag;
        sa_q   <= sa;
        sb_q   <= sb;
        bz_q   <= b_q == '0;
        prod_q <= {{WIDTH{1'b0}}, f_q[2] ? amag : bmag};
        rem_q  <= '0;
        cnt_q  <= '0;
      end
      if (state_q == CALC) begin
        cnt_q  <= cnt_q + 1'b1;
        prod_q <= f_q[2] ? {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-2:0], ~diff[WIDTH+1]} : prod_mul;
        rem_q  <= f_q[2] ? (diff[WIDTH+1] ? shifted[WIDTH:0] : diff[WIDTH:0]) : rem_q;
      end
      if (state_q == FIX && !flush) result_q <= res_d;
    end
  end
  assign result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed check of muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        ready, busy, done;
  logic [31:0] result;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] last_res = '0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .flush(flush), .ready(ready), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mdl(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    logic [63:0] p;
    logic [31:0] r;
    case (f)
      3'd0: begin p = ua * ub; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin p = sa / (b == 0 ? 64'sd1 : sb); r = (b == 0) ? 32'hFFFF_FFFF : p[31:0]; end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin p = sa % (b == 0 ? 64'sd1 : sb); r = (b == 0) ? a : p[31:0]; end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit noise);
    int busy_n = 0;
    int early = 0;
    @(negedge clk);
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        start = noise;
        op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom);
      end
      @(negedge clk);
      busy_n += int'(busy);
      if (k < 35 && done) early++;
      if (k == 20) chk("hold", result, last_res);
    end
    chk("done_at_35", 32'(done), 32'd1);
    chk("busy_cycles", 32'(busy_n), 32'd34);
    chk("no_early_done", 32'(early), 32'd0);
    chk("result", result, exp);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("done_pulse_end", {29'b0, ready, busy, done}, 32'b100);
    last_res = exp;
  endtask

  task automatic do_flush(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int k);
    int dn = 0;
    @(negedge clk);
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    for (int e = 1; e <= k; e++) begin
      @(posedge clk); #1;
      if (e == 1) start = 1'b0;
      if (e == k - 1) flush = 1'b1;
      if (e == k) flush = 1'b0;
    end
    @(negedge clk);
    chk("flush_idle", {30'b0, ready, busy}, 32'b10);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("flush_no_done", 32'(dn), 32'd0);
    chk("flush_result", result, last_res);
  endtask

  localparam int ND = 12;
  logic [2:0]  d_f [ND] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
  logic [31:0] d_a [ND] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                            32'd7, 32'd7, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
  logic [31:0] d_b [ND] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2,
                            32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
  logic [31:0] d_r [ND] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                            32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9};

  initial begin
    #2;
    chk("reset_state", {28'b0, ready, busy, done, |result}, 32'b1000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < ND; i++) do_op(d_f[i], d_a[i], d_b[i], d_r[i], i == 0);
    do_flush(3'd5, 32'd1000, 32'd7, 11);
    do_op(3'd0, 32'd3, 32'd4, 32'd12, 1'b0);
    do_flush(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 2);
    do_flush(3'd6, 32'hDEAD_BEEF, 32'd13, 35);
    @(negedge clk);
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("start_with_flush", {30'b0, ready, busy}, 32'b10);
    @(negedge clk);
    funct3 = 3'd3; op_a = 32'hFFFF_0000; op_b = 32'h0001_FFFF; start = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("async_reset", {28'b0, ready, busy, done, |result}, 32'b1000);
    @(negedge clk);
    rst_n = 1'b1;
    last_res = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_reset_quiet", {29'b0, ready, busy, done}, 32'b100);
    end
    do_op(3'd3, 32'hFFFF_0000, 32'h0001_FFFF, mdl(3'd3, 32'hFFFF_0000, 32'h0001_FFFF), 1'b0);
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f = 3'($urandom_range(0, 7));
      logic [31:0] a = $urandom;
      logic [31:0] b = $urandom;
      case ($urandom_range(0, 9))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 100));
        default: ;
      endcase
      do_op(f, a, b, mdl(f, a, b), i % 5 == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
